// File: rtl/cfa_window_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cfa_window_ctrl_pkg
// Shared definitions for the CFA window sequencing controller:
//   - FSM state encoding (IDLE / RUN / DONE)
//   - Bayer phase codes for pixel (0,0)
//   - half-window helper used to locate the window centre
// -----------------------------------------------------------------------------
package cfa_window_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] BAYER_RGGB = 2'd0;
    localparam logic [1:0] BAYER_GRBG = 2'd1;
    localparam logic [1:0] BAYER_GBRG = 2'd2;
    localparam logic [1:0] BAYER_BGGR = 2'd3;

    // Distance from the window's bottom-right pixel to its centre.
    function automatic int half_win(input int buffer_size);
        return (buffer_size - 1) / 2;
    endfunction

endpackage

// File: rtl/cfa_window_ctrl_raster_counter.sv
// -----------------------------------------------------------------------------
// cfa_window_ctrl_raster_counter
// Raster column/row counters with end-of-row / end-of-frame flags and a
// one-hot line-buffer write select that rotates at every row boundary.
//   clk, rst   : clock, asynchronous active-low reset
//   clr        : synchronous return to (0,0) with select on line 0
//   adv        : advance by one pixel
//   width      : pixels per row (latched geometry)
//   height     : rows per frame (latched geometry)
//   col, row   : position of the next pixel
//   row_sel    : one-hot write select
//   eol, eof   : current pixel is the last of its row / of the frame
// -----------------------------------------------------------------------------
module cfa_window_ctrl_raster_counter
    import cfa_window_ctrl_pkg::*;
#(
    parameter int Rows    = 5,
    parameter int ColBits = 11,
    parameter int RowBits = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               adv,
    input  logic [ColBits-1:0] width,
    input  logic [RowBits-1:0] height,
    output logic [ColBits-1:0] col,
    output logic [RowBits-1:0] row,
    output logic [Rows-1:0]    row_sel,
    output logic               eol,
    output logic               eof
);

    localparam logic [Rows-1:0] SEL_INIT = Rows'(1);

    logic [ColBits-1:0] col_q, col_d;
    logic [RowBits-1:0] row_q, row_d;
    logic [Rows-1:0]    sel_q, sel_d;

    assign eol = (col_q == width - ColBits'(1));
    assign eof = eol && (row_q == height - RowBits'(1));

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        sel_d = sel_q;
        if (clr) begin
            col_d = '0;
            row_d = '0;
            sel_d = SEL_INIT;
        end else if (adv) begin
            if (eol) begin
                col_d = '0;
                row_d = row_q + RowBits'(1);
                // Rotate left; the MSB wraps back to line 0.
                sel_d = {sel_q[Rows-2:0], sel_q[Rows-1]};
            end else begin
                col_d = col_q + ColBits'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q <= '0;
            row_q <= '0;
            sel_q <= SEL_INIT;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            sel_q <= sel_d;
        end
    end

    assign col     = col_q;
    assign row     = row_q;
    assign row_sel = sel_q;

endmodule

// File: rtl/cfa_window_ctrl.sv
// -----------------------------------------------------------------------------
// cfa_window_ctrl
// Sequencing controller for the CFA demosaic front end. Accepts a raster
// pixel stream, drives the shift buffers, rotates the line-buffer write
// select, and flags complete BufferSize x BufferSize windows together with
// the Bayer phase of the window centre.
//   clk, rst            : clock, asynchronous active-low reset
//   start, abort        : frame start pulse (IDLE only), synchronous abort
//   img_width/height    : frame geometry, latched at start
//   bayer_pattern       : phase of pixel (0,0), latched at start
//   in_valid / in_ready : pixel handshake
//   buf_en, buf_shift   : shift-buffer controls (high on accept)
//   wr_row_sel          : one-hot line-buffer write select
//   col, row            : position of the next pixel to accept
//   win_valid, cfa_phase: window complete / centre phase (registered)
//   busy, frame_done    : in RUN / end-of-frame pulse
//   cfg_err             : latched geometry was too small
// -----------------------------------------------------------------------------
module cfa_window_ctrl
    import cfa_window_ctrl_pkg::*;
#(
    parameter int BufferSize = 5,
    parameter int ColBits    = 11,
    parameter int RowBits    = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ColBits-1:0]    img_width,
    input  logic [RowBits-1:0]    img_height,
    input  logic [1:0]            bayer_pattern,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  buf_en,
    output logic                  buf_shift,
    output logic [BufferSize-1:0] wr_row_sel,
    output logic [ColBits-1:0]    col,
    output logic [RowBits-1:0]    row,
    output logic                  win_valid,
    output logic [1:0]            cfa_phase,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  cfg_err
);

    localparam int                 HALF    = half_win(BufferSize);
    localparam logic               H_ODD   = ((HALF % 2) == 1);
    localparam logic [ColBits-1:0] COL_MIN = ColBits'(BufferSize - 1);
    localparam logic [RowBits-1:0] ROW_MIN = RowBits'(BufferSize - 1);
    localparam logic [ColBits-1:0] W_MIN   = ColBits'(BufferSize);
    localparam logic [RowBits-1:0] H_MIN   = RowBits'(BufferSize);

    state_t             state_q, state_d;
    logic [ColBits-1:0] width_q;
    logic [RowBits-1:0] height_q;
    logic [1:0]         pattern_q;
    logic               cfg_err_q, cfg_err_d;
    logic               win_valid_q, win_valid_d;
    logic [1:0]         phase_q, phase_d;
    logic               latch_cfg;
    logic               cnt_clr;
    logic               accept;
    logic               adv;
    logic               eol;
    logic               eof;
    logic               geom_bad;

    assign in_ready  = (state_q == ST_RUN);
    assign accept    = in_valid && in_ready;
    assign buf_en    = accept;
    assign buf_shift = accept;
    // Abort wins over a same-cycle accept: the position does not advance.
    assign adv       = accept && !abort;
    assign geom_bad  = (img_width < W_MIN) || (img_height < H_MIN);

    cfa_window_ctrl_raster_counter #(
        .Rows    (BufferSize),
        .ColBits (ColBits),
        .RowBits (RowBits)
    ) u_raster (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .adv     (adv),
        .width   (width_q),
        .height  (height_q),
        .col     (col),
        .row     (row),
        .row_sel (wr_row_sel),
        .eol     (eol),
        .eof     (eof)
    );

    always_comb begin
        state_d   = state_q;
        cfg_err_d = cfg_err_q;
        latch_cfg = 1'b0;
        cnt_clr   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    latch_cfg = 1'b1;
                    cnt_clr   = 1'b1;
                    cfg_err_d = geom_bad;
                    state_d   = geom_bad ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    cnt_clr = 1'b1;
                    state_d = ST_IDLE;
                end else if (accept && eof) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                cnt_clr = abort;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The window whose bottom-right pixel was just accepted is complete once
    // the buffers have shifted, so the flag is registered by one cycle. Only
    // the parity of the centre coordinate matters, and an odd half-window
    // flips that parity.
    assign win_valid_d = adv && (row >= ROW_MIN) && (col >= COL_MIN);
    assign phase_d     = pattern_q ^ {row[0] ^ H_ODD, col[0] ^ H_ODD};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            width_q     <= '0;
            height_q    <= '0;
            pattern_q   <= '0;
            cfg_err_q   <= 1'b0;
            win_valid_q <= 1'b0;
            phase_q     <= '0;
        end else begin
            state_q     <= state_d;
            cfg_err_q   <= cfg_err_d;
            win_valid_q <= win_valid_d;
            if (win_valid_d) begin
                phase_q <= phase_d;
            end
            if (latch_cfg) begin
                width_q   <= img_width;
                height_q  <= img_height;
                pattern_q <= bayer_pattern;
            end
        end
    end

    assign win_valid  = win_valid_q;
    assign cfa_phase  = phase_q;
    assign busy       = (state_q == ST_RUN);
    assign frame_done = (state_q == ST_DONE) && !abort;
    assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_cfa_window_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cfa_window_ctrl
// Directed frames drive the controller; expected windows (cycle + phase) are
// queued when an accept is issued and a negedge monitor pops and compares
// them whenever win_valid is presented.
// -----------------------------------------------------------------------------
module tb_cfa_window_ctrl;

    localparam int BS = 5;
    localparam int CB = 11;
    localparam int RB = 11;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          in_valid = 1'b0;
    logic [CB-1:0] img_width = '0;
    logic [RB-1:0] img_height = '0;
    logic [1:0]    bayer_pattern = '0;

    logic          in_ready, buf_en, buf_shift, win_valid, busy, frame_done, cfg_err;
    logic [BS-1:0] wr_row_sel;
    logic [CB-1:0] col;
    logic [RB-1:0] row;
    logic [1:0]    cfa_phase;

    cfa_window_ctrl #(.BufferSize(BS), .ColBits(CB), .RowBits(RB)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .img_width(img_width), .img_height(img_height), .bayer_pattern(bayer_pattern),
        .in_valid(in_valid), .in_ready(in_ready), .buf_en(buf_en), .buf_shift(buf_shift),
        .wr_row_sel(wr_row_sel), .col(col), .row(row), .win_valid(win_valid),
        .cfa_phase(cfa_phase), .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [1:0] ph;
    } exp_t;

    exp_t       q[$];
    exp_t       mon_e;
    logic [1:0] seen_ph[$];
    int checks = 0;
    int failures = 0;
    int win_cnt = 0;
    int fd_cnt = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every presented window must match the head of the queue.
    always @(negedge clk) begin
        if (rst) begin
            if (frame_done) fd_cnt++;
            if (win_valid) begin
                win_cnt++;
                seen_ph.push_back(cfa_phase);
                if (q.size() == 0) begin
                    chk("win_valid_unexpected", 1, 0);
                end else begin
                    mon_e = q.pop_front();
                    chk("win_cycle", cyc, mon_e.cyc);
                    chk("cfa_phase", int'(cfa_phase), int'(mon_e.ph));
                end
            end
        end
    end

    // kill: 0 none, 1 abort at (kr,kc), 2 reset at (kr,kc). Entered and left
    // one time unit after a rising edge.
    task automatic run_frame(input int w, input int h, input logic [1:0] pat,
                             input int stall, input int kill, input int kr,
                             input int kc, input int exp_win);
        int r = 0;
        int c = 0;
        int guard = 0;
        int win0;
        int fd0;
        int cr;
        int cc;
        logic v;
        logic [1:0] eph;
        win0 = win_cnt;
        fd0  = fd_cnt;
        seen_ph.delete();
        img_width     = CB'(w);
        img_height    = RB'(h);
        bayer_pattern = pat;
        start         = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Geometry changes while running must be ignored.
        img_width     = CB'(3);
        img_height    = RB'(3);
        bayer_pattern = ~pat;
        chk("busy_after_start", int'(busy), 1);
        while (r < h && guard < 5000) begin
            guard++;
            if (kill != 0 && r == kr && c == kc) begin
                in_valid = 1'b1;
                if (kill == 1) begin
                    abort = 1'b1;
                    @(posedge clk); #1;
                    abort    = 1'b0;
                    in_valid = 1'b0;
                end else begin
                    rst = 1'b0;
                    #1;
                    chk("rst_buf_en", int'(buf_en), 0);
                end
                q.delete();
                chk("kill_busy", int'(busy), 0);
                chk("kill_col", int'(col), 0);
                chk("kill_row", int'(row), 0);
                chk("kill_sel", int'(wr_row_sel), 1);
                chk("kill_ready", int'(in_ready), 0);
                chk("kill_frame_done", int'(frame_done), 0);
                chk("kill_win_valid", int'(win_valid), 0);
                in_valid = 1'b0;
                if (kill == 2) begin
                    chk("rst_cfa_phase", int'(cfa_phase), 0);
                    @(posedge clk); #1;
                    rst = 1'b1;
                end
                @(posedge clk); #1;
                chk("kill_no_frame_done", fd_cnt - fd0, 0);
                chk("kill_idle_busy", int'(busy), 0);
                return;
            end
            v = (stall != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid = v;
            #1;
            chk("in_ready", int'(in_ready), 1);
            chk("buf_en", int'(buf_en), int'(v));
            chk("buf_shift", int'(buf_shift), int'(v));
            chk("col", int'(col), c);
            chk("row", int'(row), r);
            chk("wr_row_sel", int'(wr_row_sel), 1 << (r % BS));
            if (v) begin
                if (r >= BS - 1 && c >= BS - 1) begin
                    cr  = r - (BS - 1) / 2;
                    cc  = c - (BS - 1) / 2;
                    eph = pat ^ {cr[0], cc[0]};
                    q.push_back('{cyc: cyc + 1, ph: eph});
                end
                if (c == w - 1) begin
                    c = 0;
                    r++;
                end else begin
                    c++;
                end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("frame_complete", r, h);
        #1;
        chk("frame_done_pulse", int'(frame_done), 1);
        chk("done_busy", int'(busy), 0);
        chk("done_ready", int'(in_ready), 0);
        chk("done_cfg_err", int'(cfg_err), 0);
        @(posedge clk); #1;
        chk("frame_done_single", int'(frame_done), 0);
        chk("win_count", win_cnt - win0, exp_win);
        chk("frame_done_count", fd_cnt - fd0, 1);
        chk("queue_drained", q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_buf_en", int'(buf_en), 0);
        chk("rst_col", int'(col), 0);
        chk("rst_row", int'(row), 0);
        chk("rst_wr_row_sel", int'(wr_row_sel), 1);
        chk("rst_win_valid", int'(win_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_cfg_err", int'(cfg_err), 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Basic frame: 8x6 RGGB, 4x2 windows, first centre (2,2) is phase 0.
        run_frame(8, 6, 2'd0, 0, 0, 0, 0, 8);
        chk("basic_first_phase", (seen_ph.size() > 0) ? int'(seen_ph[0]) : -1, 0);

        // Phase check: 6x5 GRBG, centres (2,2) and (2,3).
        run_frame(6, 5, 2'd1, 0, 0, 0, 0, 2);
        chk("grbg_phase_c22", (seen_ph.size() > 0) ? int'(seen_ph[0]) : -1, 1);
        chk("grbg_phase_c23", (seen_ph.size() > 1) ? int'(seen_ph[1]) : -1, 0);

        // Stalled basic frame.
        run_frame(8, 6, 2'd0, 1, 0, 0, 0, 8);

        // Row rotation across a 7-row frame; 7 rotations end on line 2.
        run_frame(5, 7, 2'd3, 0, 0, 0, 0, 3);
        chk("rot_final_sel", int'(wr_row_sel), 4);

        // Bad geometry: width below the window size.
        fd0 = fd_cnt;
        img_width  = CB'(4);
        img_height = RB'(10);
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        #1;
        chk("bad_cfg_err", int'(cfg_err), 1);
        chk("bad_frame_done", int'(frame_done), 1);
        chk("bad_in_ready", int'(in_ready), 0);
        chk("bad_busy", int'(busy), 0);
        @(posedge clk); #1;
        chk("bad_cfg_err_hold", int'(cfg_err), 1);
        chk("bad_frame_done_end", int'(frame_done), 0);
        chk("bad_in_ready_idle", int'(in_ready), 0);
        chk("bad_frame_done_count", fd_cnt - fd0, 1);

        // Abort at (3,2), then a clean frame.
        run_frame(8, 6, 2'd0, 0, 1, 3, 2, 0);
        run_frame(8, 6, 2'd2, 0, 0, 0, 0, 8);

        // Reset mid-frame at (5,5), then a clean frame.
        run_frame(8, 6, 2'd0, 0, 2, 5, 5, 0);
        run_frame(8, 6, 2'd0, 0, 0, 0, 0, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
